// File: rtl/gpu_bus_pkg.sv
// gpu_bus_pkg: shared encodings, address windows and helpers for the video bus exerciser
package gpu_bus_pkg;
  typedef enum logic [1:0] {
    PAT_FILL = 2'd0,
    PAT_INCR = 2'd1,
    PAT_LFSR = 2'd2,
    PAT_RSVD = 2'd3
  } pat_mode_e;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_SETUP,
    ST_WR_STROBE,
    ST_WR_HOLD,
    ST_RD_SETUP,
    ST_RD_STROBE,
    ST_RD_HOLD,
    ST_DONE
  } state_e;
  localparam logic [15:0] VRAM_LO = 16'h8000;
  localparam logic [15:0] VRAM_HI = 16'h9FFF;
  localparam logic [15:0] OAM_LO = 16'hFE00;
  localparam logic [15:0] OAM_HI = 16'hFE9F;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  // VRAM is off-limits in mode 3, OAM in modes 2 and 3
  function automatic logic addr_blocked(input logic [15:0] a, input logic [1:0] m);
    return (m == 2'd3 && a >= VRAM_LO && a <= VRAM_HI) || (m[1] && a >= OAM_LO && a <= OAM_HI);
  endfunction
  // Fibonacci x^8+x^6+x^5+x^4+1, shifting towards the MSB
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/gpu_bus_exerciser_if.sv
// gpu_bus_exerciser_if: CPU-side video bus between the exerciser and gpu_top
interface gpu_bus_exerciser_if;
  logic [15:0] A_video;
  logic [7:0] di_video;
  logic [7:0] do_video;
  logic mem_enable_video;
  logic rd_n_video;
  logic wr_n_video;
  logic [1:0] mode_video;
  modport master (
    output A_video, di_video, mem_enable_video, rd_n_video, wr_n_video,
    input do_video, mode_video
  );
  modport slave (
    input A_video, di_video, mem_enable_video, rd_n_video, wr_n_video,
    output do_video, mode_video
  );
endinterface

// File: rtl/gpu_bus_pattern_gen.sv
// gpu_bus_pattern_gen: registered byte pattern source, loaded from a seed and stepped per index
module gpu_bus_pattern_gen
  import gpu_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       step,
  input  logic [1:0] mode,
  input  logic [7:0] seed,
  output logic [7:0] pat
);
  logic [7:0] pat_q, pat_d;
  // load wins over step; FILL and the reserved mode simply hold the seed
  always_comb begin
    pat_d = pat_q;
    if (load)
      pat_d = (mode == PAT_LFSR && seed == 8'd0) ? 8'h01 : seed;
    else if (step)
      pat_d = mode == PAT_INCR ? pat_q + 8'd1 : mode == PAT_LFSR ? lfsr_next(pat_q) : pat_q;
  end
  // pattern register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pat_q <= 8'd0;
    else pat_q <= pat_d;
  assign pat = pat_q;
endmodule

// File: rtl/gpu_bus_exerciser.sv
// gpu_bus_exerciser: pattern write/readback master for the gpu_top video bus plus interrupt acker
module gpu_bus_exerciser
  import gpu_bus_pkg::*;
#(
  parameter int LEN_W = 13,
  parameter int STROBE_CYC = 2,
  parameter int NUM_INT = 2,
  parameter int CNT_W = 8,
  parameter int ERR_W = 8
) (
  input  logic                     clk,
  input  logic                     top_rst_b,
  input  logic                     start,
  input  logic [1:0]               pat_mode,
  input  logic [7:0]               seed,
  input  logic [15:0]              base_addr,
  input  logic [LEN_W-1:0]         length,
  input  logic                     check_en,
  output logic                     busy,
  output logic                     done,
  output logic [ERR_W-1:0]         err_count,
  output logic [15:0]              first_err_addr,
  gpu_bus_exerciser_if.master      bus,
  input  logic [NUM_INT-1:0]       int_req,
  output logic [NUM_INT-1:0]       int_ack,
  output logic [NUM_INT*CNT_W-1:0] int_count
);
  localparam int SC_W = STROBE_CYC > 1 ? $clog2(STROBE_CYC) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(STROBE_CYC - 1);

  state_e state_q, state_d;
  logic [LEN_W-1:0] idx_q, idx_d, len_q, len_d;
  logic [15:0] addr_q, addr_d, base_q, base_d, ferr_q, ferr_d;
  logic [SC_W-1:0] sc_q, sc_d;
  logic [1:0] mode_q, mode_d;
  logic [7:0] seed_q, seed_d, rdata_q, rdata_d;
  logic chk_q, chk_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic busy_q, busy_d, done_q, done_d, mem_en_q, mem_en_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic gen_load, gen_step, last, sc_last;
  logic [1:0] gen_mode;
  logic [7:0] gen_seed, pat;

  assign last = idx_q == len_q - LEN_W'(1);
  assign sc_last = sc_q == SC_LAST;
  assign gen_mode = state_q == ST_IDLE ? pat_mode : mode_q;
  assign gen_seed = state_q == ST_IDLE ? seed : seed_q;

  gpu_bus_pattern_gen u_pat (
    .clk  (clk),
    .rst_n(top_rst_b),
    .load (gen_load),
    .step (gen_step),
    .mode (gen_mode),
    .seed (gen_seed),
    .pat  (pat)
  );

  // next-state and next-output logic; bus outputs are derived from the next state
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    len_d = len_q;
    addr_d = addr_q;
    base_d = base_q;
    mode_d = mode_q;
    seed_d = seed_q;
    chk_d = chk_q;
    rdata_d = rdata_q;
    err_d = err_q;
    ferr_d = ferr_q;
    gen_load = 1'b0;
    gen_step = 1'b0;
    sc_d = (state_q == ST_WR_STROBE || state_q == ST_RD_STROBE) ? sc_q + SC_W'(1) : '0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = length == '0 ? ST_DONE : ST_WR_SETUP;
        len_d = length;
        base_d = base_addr;
        mode_d = pat_mode;
        seed_d = seed;
        chk_d = check_en;
        idx_d = '0;
        addr_d = base_addr;
        err_d = '0;
        ferr_d = '0;
        gen_load = 1'b1;
      end
      ST_WR_SETUP: if (!addr_blocked(addr_q, bus.mode_video)) state_d = ST_WR_STROBE;
      ST_WR_STROBE: if (sc_last) state_d = ST_WR_HOLD;
      ST_WR_HOLD: begin
        if (!last) begin
          state_d = ST_WR_SETUP;
          idx_d = idx_q + LEN_W'(1);
          addr_d = addr_q + 16'd1;
          gen_step = 1'b1;
        end else if (chk_q) begin
          state_d = ST_RD_SETUP;
          idx_d = '0;
          addr_d = base_q;
          gen_load = 1'b1;
        end else
          state_d = ST_DONE;
      end
      ST_RD_SETUP: if (!addr_blocked(addr_q, bus.mode_video)) state_d = ST_RD_STROBE;
      ST_RD_STROBE: if (sc_last) begin
        state_d = ST_RD_HOLD;
        rdata_d = bus.do_video;
      end
      ST_RD_HOLD: begin
        if (rdata_q != pat) begin
          err_d = &err_q ? err_q : err_q + ERR_W'(1);
          ferr_d = err_q == '0 ? addr_q : ferr_q;
        end
        if (!last) begin
          state_d = ST_RD_SETUP;
          idx_d = idx_q + LEN_W'(1);
          addr_d = addr_q + 16'd1;
          gen_step = 1'b1;
        end else
          state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = !(state_d inside {ST_IDLE, ST_DONE});
    mem_en_d = busy_d;
    done_d = state_d == ST_DONE;
    wr_n_d = state_d != ST_WR_STROBE;
    rd_n_d = state_d != ST_RD_STROBE;
  end

  // FSM and registered bus outputs; reset forces the strobes high at once
  always_ff @(posedge clk or negedge top_rst_b)
    if (!top_rst_b) begin
      state_q <= ST_IDLE;
      idx_q <= '0;
      len_q <= '0;
      addr_q <= '0;
      base_q <= '0;
      mode_q <= '0;
      seed_q <= '0;
      chk_q <= 1'b0;
      rdata_q <= '0;
      err_q <= '0;
      ferr_q <= '0;
      sc_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      mem_en_q <= 1'b0;
      wr_n_q <= 1'b1;
      rd_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      len_q <= len_d;
      addr_q <= addr_d;
      base_q <= base_d;
      mode_q <= mode_d;
      seed_q <= seed_d;
      chk_q <= chk_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      ferr_q <= ferr_d;
      sc_q <= sc_d;
      busy_q <= busy_d;
      done_q <= done_d;
      mem_en_q <= mem_en_d;
      wr_n_q <= wr_n_d;
      rd_n_q <= rd_n_d;
    end

  logic [NUM_INT-1:0] ack_q, ack_d;
  logic [NUM_INT-1:0][CNT_W-1:0] icnt_q, icnt_d;
  // ack a request unless it was acked last cycle, so held requests ack every other cycle
  always_comb begin
    ack_d = int_req & ~ack_q;
    for (int i = 0; i < NUM_INT; i++)
      icnt_d[i] = (ack_d[i] && !(&icnt_q[i])) ? icnt_q[i] + CNT_W'(1) : icnt_q[i];
  end
  // interrupt ack and count registers
  always_ff @(posedge clk or negedge top_rst_b)
    if (!top_rst_b) begin
      ack_q <= '0;
      icnt_q <= '0;
    end else begin
      ack_q <= ack_d;
      icnt_q <= icnt_d;
    end

  assign busy = busy_q;
  assign done = done_q;
  assign err_count = err_q;
  assign first_err_addr = ferr_q;
  assign int_ack = ack_q;
  assign int_count = icnt_q;
  assign bus.A_video = addr_q;
  assign bus.di_video = pat;
  assign bus.mem_enable_video = mem_en_q;
  assign bus.rd_n_video = rd_n_q;
  assign bus.wr_n_video = wr_n_q;
endmodule

// File: doc/gpu_bus_exerciser.md
Name: gpu_bus_exerciser

Overview:
Parametrised stimulus and checker master for the gpu_top CPU-side video bus. It replaces tied-off bench drivers for the gpu_top memory bus and interrupt handshake. On a start pulse it writes a generated byte pattern to a contiguous address range, optionally reads the range back and compares. In parallel it acknowledges and counts interrupt requests. It obeys mode_video access blocking for VRAM and OAM, so it can exercise gpu_top during live display.

Parameters:
LEN_W, 13, width of length and index counters; max burst is 2^LEN_W-1 bytes.
STROBE_CYC, 2, cycles rd_n/wr_n held low per access (>=1).
NUM_INT, 2, interrupt request/ack channels.
CNT_W, 8, width of each per-channel saturating interrupt counter.
ERR_W, 8, width of saturating mismatch counter.

Ports:
clk  in  1  single block clock (CPU domain).
top_rst_b  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; accepted only in IDLE.
pat_mode  in  2  0 FILL, 1 INCR, 2 LFSR, 3 reserved (treated as FILL).
seed  in  8  pattern seed.
base_addr  in  16  first address.
length  in  LEN_W  byte count.
check_en  in  1  perform readback/compare pass.
busy  out  1  high from accepted start until DONE.
done  out  1  one-cycle pulse at completion.
err_count  out  ERR_W  saturating mismatch count for the last run.
first_err_addr  out  16  address of first mismatch; 0 if none.
A_video  out  16  bus address.
di_video  out  8  write data.
do_video  in  8  read data from gpu_top.
mem_enable_video  out  1  high during SETUP/STROBE/HOLD phases.
rd_n_video  out  1  active-low read strobe.
wr_n_video  out  1  active-low write strobe.
mode_video  in  2  gpu_top LCD mode.
int_req  in  NUM_INT  interrupt requests.
int_ack  out  NUM_INT  interrupt acknowledges.
int_count  out  NUM_INT*CNT_W  packed per-channel counts, channel 0 in LSBs.

Behaviour:
- Reset values: busy=0, done=0, err_count=0, first_err_addr=0, A_video=0, di_video=0, mem_enable_video=0, rd_n_video=1, wr_n_video=1, int_ack=0, int_count=0, FSM=IDLE.
- Reset mid-run aborts immediately. No done pulse. Strobes return high asynchronously.
- Inputs are latched on an accepted start. Inputs changing mid-run have no effect. start while busy is ignored.
- Accepted start clears err_count and first_err_addr.
- States:
  - IDLE -> WR_SETUP on start. If length==0, go directly to DONE.
  - WR_SETUP: drive A_video and di_video; wait while the address is blocked, then go to WR_STROBE.
  - WR_STROBE: wr_n_video=0 for STROBE_CYC cycles, then go to WR_HOLD.
  - WR_HOLD (1 cycle, strobe high, address and data held): next index, or RD_SETUP with index reset if check_en, else DONE.
  - RD_SETUP / RD_STROBE / RD_HOLD mirror the write states with rd_n_video. do_video is sampled on the last RD_STROBE cycle. The compare happens in RD_HOLD.
  - DONE: done=1 for one cycle, busy drops in the same cycle, then IDLE.
- Blocking:
  - VRAM 0x8000-0x9FFF is blocked when mode_video==3.
  - OAM 0xFE00-0xFE9F is blocked when mode_video is 2 or 3.
  - Blocking is evaluated only in SETUP. Once a strobe starts it completes.
- Address = base_addr + index, modulo 2^16. 0xFFFF wraps to 0x0000.
- Pattern per index i:
  - FILL = seed.
  - INCR = (seed+i) mod 256.
  - LFSR = 8-bit Fibonacci x^8+x^6+x^5+x^4+1, stepped once per index. Seed 0 is replaced by 0x01.
  - The readback pass regenerates the pattern from the latched seed.
- Mismatch: err_count increments, saturating at all-ones. first_err_addr is captured on the first mismatch only.
- Interrupts, independent of the FSM and per channel:
  - int_req[i]=1 with int_ack[i]=0 -> int_ack[i]=1 next cycle, for one cycle; the counter increments, saturating.
  - A held request re-acks every second cycle.
  - Simultaneous requests on multiple channels are all acked in the same cycle.

Decomposition:
- Shared package gpu_bus_pkg holds:
  - pattern mode encodings;
  - FSM state encoding;
  - VRAM/OAM bound constants;
  - the LFSR tap mask.
- One sub-module, gpu_bus_pattern_gen: seed load, step enable and mode in; byte out; 1-cycle registered.

Test Plan:
- FILL 0xA5, base 0x8000, length 4, check_en=1, do_video looped from a 64-entry model RAM, mode_video=0:
  - 4 writes of 0xA5 at 0x8000-0x8003, each strobe 2 cycles;
  - done after 4x4 + 4x4 + 1 cycles;
  - err_count=0.
- INCR seed 0xFE, base 0xFFFE, length 3, no check:
  - writes 0xFE at 0xFFFE, 0xFF at 0xFFFF, 0x00 at 0x0000.
- mode_video=3 held 10 cycles, base 0x8010:
  - mem_enable high, wr_n stays 1 for those 10 cycles;
  - strobe starts the cycle after mode_video goes to 0.
- LFSR seed 0x00, length 2, model RAM corrupts byte 1:
  - writes 0x01 then 0x02;
  - err_count=1, first_err_addr=base+1.
- int_req=2'b11 pulsed 1 cycle, then bit0 held 6 cycles:
  - int_ack=2'b11 once;
  - bit0 acks 3 more times;
  - int_count = {1, 4}, i.e. channel 1 count 1, channel 0 count 4.
- top_rst_b low during WR_STROBE:
  - wr_n_video=1 immediately;
  - no done pulse;
  - a fresh start afterwards runs normally.
